// File: rtl/pipelined_init_bram.sv
// rtl/pipelined_init_bram.sv - dual-port BRAM that clears itself after reset and serves pipelined reads
// Memory contents are only defined by the post-reset CLEAR sweep; port A wins same-address write races.

module pipelined_init_bram #(
    parameter int                    DATA_WIDTH   = 36,
    parameter int                    ADDR_WIDTH   = 9,
    parameter int                    DEPTH        = 1 << ADDR_WIDTH,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  REA,
    input  logic                  REB,
    input  logic                  WEA,
    input  logic                  WEB,
    input  logic [ADDR_WIDTH-1:0] RD_ADDRA,
    input  logic [ADDR_WIDTH-1:0] RD_ADDRB,
    input  logic [ADDR_WIDTH-1:0] WR_ADDRA,
    input  logic [ADDR_WIDTH-1:0] WR_ADDRB,
    input  logic [DATA_WIDTH-1:0] DIA,
    input  logic [DATA_WIDTH-1:0] DIB,
    output logic [DATA_WIDTH-1:0] DOA,
    output logic [DATA_WIDTH-1:0] DOB,
    output logic                  VALIDA,
    output logic                  VALIDB,
    output logic                  INIT,
    output logic                  COLLIDE
);

    localparam int                    MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    ready;
    logic                    acc_ra;
    logic                    acc_rb;
    logic                    wr_a;
    logic                    wr_b;
    logic                    collide_now;
    logic [DATA_WIDTH-1:0]   rd_word_a;
    logic [DATA_WIDTH-1:0]   rd_word_b;

    logic [READ_LATENCY-1:0] va_pipe;
    logic [READ_LATENCY-1:0] vb_pipe;
    logic [DATA_WIDTH-1:0]   da_pipe [READ_LATENCY];
    logic [DATA_WIDTH-1:0]   db_pipe [READ_LATENCY];

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return {1'b0, addr} < DEPTH_W;
    endfunction

    assign ready  = (state == READY);
    assign acc_ra = ready && REA && !WEA;
    assign acc_rb = ready && REB && !WEB;
    assign wr_a   = ready && WEA && in_range(WR_ADDRA);
    // Port B yields to port A on a shared address; that race is what COLLIDE records.
    assign collide_now = wr_a && WEB && (WR_ADDRA == WR_ADDRB);
    assign wr_b   = ready && WEB && in_range(WR_ADDRB) && !collide_now;

    assign rd_word_a = in_range(RD_ADDRA) ? mem[RD_ADDRA[MEM_AW-1:0]] : INIT_VALUE;
    assign rd_word_b = in_range(RD_ADDRB) ? mem[RD_ADDRB[MEM_AW-1:0]] : INIT_VALUE;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= CLEAR;
            clr_cnt <= '0;
            INIT    <= 1'b0;
            COLLIDE <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    if (clr_cnt == LAST_ADDR) begin
                        state   <= READY;
                        INIT    <= 1'b1;
                        clr_cnt <= '0;
                    end else begin
                        clr_cnt <= clr_cnt + 1'b1;
                    end
                end
                READY: begin
                    if (collide_now) begin
                        COLLIDE <= 1'b1;
                    end
                end
                default: begin
                    state   <= CLEAR;
                    clr_cnt <= '0;
                    INIT    <= 1'b0;
                end
            endcase
        end
    end

    // Array reads sample before the same-edge writes land, so cross-port reads see old data.
    always_ff @(posedge CLK) begin
        if (state == CLEAR) begin
            mem[clr_cnt[MEM_AW-1:0]] <= INIT_VALUE;
        end
        if (wr_a) begin
            mem[WR_ADDRA[MEM_AW-1:0]] <= DIA;
        end
        if (wr_b) begin
            mem[WR_ADDRB[MEM_AW-1:0]] <= DIB;
        end
        if (acc_ra) begin
            da_pipe[0] <= rd_word_a;
        end
        if (acc_rb) begin
            db_pipe[0] <= rd_word_b;
        end
        for (int i = 1; i < READ_LATENCY; i++) begin
            da_pipe[i] <= da_pipe[i-1];
            db_pipe[i] <= db_pipe[i-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            va_pipe <= '0;
            vb_pipe <= '0;
            VALIDA  <= 1'b0;
            VALIDB  <= 1'b0;
            DOA     <= '0;
            DOB     <= '0;
        end else begin
            va_pipe[0] <= acc_ra;
            vb_pipe[0] <= acc_rb;
            for (int i = 1; i < READ_LATENCY; i++) begin
                va_pipe[i] <= va_pipe[i-1];
                vb_pipe[i] <= vb_pipe[i-1];
            end
            VALIDA <= va_pipe[READ_LATENCY-1];
            VALIDB <= vb_pipe[READ_LATENCY-1];
            if (va_pipe[READ_LATENCY-1]) begin
                DOA <= da_pipe[READ_LATENCY-1];
            end
            if (vb_pipe[READ_LATENCY-1]) begin
                DOB <= db_pipe[READ_LATENCY-1];
            end
        end
    end

endmodule

// File: tb/tb_pipelined_init_bram.sv
// tb/tb_pipelined_init_bram.sv - scoreboard bench for pipelined_init_bram at read latency 1 and 2
// Two DUTs share stimulus; a behavioural memory model feeds per-port expectation queues.

module tb_pipelined_init_bram;

    localparam int            DW    = 36;
    localparam int            AW    = 5;
    localparam int            DEPTH = 16;
    localparam logic [DW-1:0] IV    = 36'h5A5A5A5A5;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          rea = 1'b0, reb = 1'b0, wea = 1'b0, web = 1'b0;
    logic [AW-1:0] ra = '0, rb = '0, wa = '0, wb = '0;
    logic [DW-1:0] da = '0, db = '0;

    logic [DW-1:0] doa1, dob1, doa2, dob2;
    logic          vala1, valb1, vala2, valb2;
    logic          init1, init2, col1, col2;

    pipelined_init_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                          .READ_LATENCY(1), .INIT_VALUE(IV)) u_rl1 (
        .CLK(CLK), .RST(RST), .REA(rea), .REB(reb), .WEA(wea), .WEB(web),
        .RD_ADDRA(ra), .RD_ADDRB(rb), .WR_ADDRA(wa), .WR_ADDRB(wb),
        .DIA(da), .DIB(db), .DOA(doa1), .DOB(dob1),
        .VALIDA(vala1), .VALIDB(valb1), .INIT(init1), .COLLIDE(col1));

    pipelined_init_bram #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH),
                          .READ_LATENCY(2), .INIT_VALUE(IV)) u_rl2 (
        .CLK(CLK), .RST(RST), .REA(rea), .REB(reb), .WEA(wea), .WEB(web),
        .RD_ADDRA(ra), .RD_ADDRB(rb), .WR_ADDRA(wa), .WR_ADDRB(wb),
        .DIA(da), .DIB(db), .DOA(doa2), .DOB(dob2),
        .VALIDA(vala2), .VALIDB(valb2), .INIT(init2), .COLLIDE(col2));

    always #5 CLK = ~CLK;

    typedef struct {
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    int            tests = 0;
    int            fails = 0;
    int            cyc   = 0;
    // Queue index: 0 = A/RL1, 1 = B/RL1, 2 = A/RL2, 3 = B/RL2
    exp_t          q0[$], q1[$], q2[$], q3[$];
    logic [DW-1:0] mem_m [32];
    logic [DW-1:0] last_m [4];
    int            cnt_m;
    bit            collide_m;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int qsize(input int idx);
        case (idx)
            0: return q0.size();
            1: return q1.size();
            2: return q2.size();
            default: return q3.size();
        endcase
    endfunction

    function automatic exp_t qfront(input int idx);
        case (idx)
            0: return q0[0];
            1: return q1[0];
            2: return q2[0];
            default: return q3[0];
        endcase
    endfunction

    task automatic qpop(input int idx);
        case (idx)
            0: void'(q0.pop_front());
            1: void'(q1.pop_front());
            2: void'(q2.pop_front());
            default: void'(q3.pop_front());
        endcase
    endtask

    task automatic model_reset();
        q0.delete(); q1.delete(); q2.delete(); q3.delete();
        for (int i = 0; i < 32; i++) mem_m[i] = IV;
        for (int i = 0; i < 4; i++) last_m[i] = '0;
        cnt_m     = 0;
        collide_m = 0;
    endtask

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        return (int'(a) < DEPTH) ? mem_m[a] : IV;
    endfunction

    // Reference model: memory becomes usable DEPTH edges after reset release.
    always @(posedge CLK) begin
        exp_t e;
        cyc++;
        if (!RST) begin
            if (cnt_m == DEPTH) begin
                if (rea && !wea) begin
                    e.data = model_read(ra);
                    e.cyc = cyc + 1; q0.push_back(e);
                    e.cyc = cyc + 2; q2.push_back(e);
                end
                if (reb && !web) begin
                    e.data = model_read(rb);
                    e.cyc = cyc + 1; q1.push_back(e);
                    e.cyc = cyc + 2; q3.push_back(e);
                end
                if (wea && wb == wa && web && int'(wa) < DEPTH) collide_m = 1;
                if (web && int'(wb) < DEPTH && !(wea && wa == wb)) mem_m[wb] = db;
                if (wea && int'(wa) < DEPTH) mem_m[wa] = da;
            end else begin
                cnt_m++;
            end
        end
    end

    task automatic mon_port(input int idx, input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (v) begin
            if (qsize(idx) == 0) begin
                tests++;
                fails++;
                $display("FAIL valid_unexpected p%0d: got 1 expected 0 (cycle %0d)", idx, cyc);
            end else begin
                e = qfront(idx);
                qpop(idx);
                check($sformatf("valid_cycle p%0d", idx), DW'(cyc), DW'(e.cyc));
                check($sformatf("read_data p%0d", idx), d, e.data);
                last_m[idx] = e.data;
            end
        end else begin
            if (qsize(idx) > 0 && qfront(idx).cyc <= cyc) begin
                tests++;
                fails++;
                $display("FAIL valid_missing p%0d: got 0 expected 1 (cycle %0d)", idx, cyc);
                qpop(idx);
            end
            check($sformatf("do_hold p%0d", idx), d, last_m[idx]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " doa1"}, doa1, '0);
        check({tag, " dob1"}, dob1, '0);
        check({tag, " doa2"}, doa2, '0);
        check({tag, " dob2"}, dob2, '0);
        check({tag, " valids"}, DW'({vala1, valb1, vala2, valb2}), '0);
        check({tag, " init"}, DW'({init1, init2}), '0);
        check({tag, " collide"}, DW'({col1, col2}), '0);
    endtask

    always @(negedge CLK) begin
        if (RST) begin
            check_reset_outputs("in_reset");
        end else if (cyc > 0) begin
            check("init1", DW'(init1), DW'(cnt_m == DEPTH));
            check("init2", DW'(init2), DW'(cnt_m == DEPTH));
            check("collide1", DW'(col1), DW'(collide_m));
            check("collide2", DW'(col2), DW'(collide_m));
            mon_port(0, vala1, doa1);
            mon_port(1, valb1, dob1);
            mon_port(2, vala2, doa2);
            mon_port(3, valb2, dob2);
        end
    end

    // Inputs are set just after an edge and sampled at the following edge.
    task automatic step(input logic i_rea, input logic i_reb, input logic i_wea, input logic i_web,
                        input logic [AW-1:0] i_ra, input logic [AW-1:0] i_rb,
                        input logic [AW-1:0] i_wa, input logic [AW-1:0] i_wb,
                        input logic [DW-1:0] i_da, input logic [DW-1:0] i_db);
        rea = i_rea; reb = i_reb; wea = i_wea; web = i_web;
        ra = i_ra; rb = i_rb; wa = i_wa; wb = i_wb; da = i_da; db = i_db;
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic rand_step();
        logic [AW-1:0] a_w, b_w;
        a_w = AW'($urandom_range(0, 19));
        b_w = ($urandom_range(0, 7) == 0) ? a_w : AW'($urandom_range(0, 19));
        if (a_w == b_w && int'(a_w) >= DEPTH) b_w = a_w - AW'(DEPTH);
        step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
             AW'($urandom_range(0, 19)), AW'($urandom_range(0, 19)), a_w, b_w,
             DW'({$urandom(), $urandom()}), DW'({$urandom(), $urandom()}));
    endtask

    task automatic async_reset(input int hold);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("reset_immediate");
        repeat (hold) @(posedge CLK);
        #1;
        RST = 1'b0;
    endtask

    initial begin
        #1;
        RST = 1'b1;
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Requests during the clear sweep must be ignored.
        for (int i = 0; i < DEPTH; i++) rand_step();
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, AW'(i), AW'(DEPTH - 1 - i), '0, '0, '0, '0);

        step(0, 0, 1, 0, '0, '0, 5, '0, 36'hABC, '0);
        step(0, 1, 0, 0, '0, 5, '0, '0, '0, '0);
        step(0, 0, 1, 1, '0, '0, 3, 3, 36'h1, 36'h2);
        step(1, 0, 0, 0, 3, '0, '0, '0, '0, '0);
        step(0, 1, 1, 0, '0, 7, 7, '0, 36'h55, '0);
        step(1, 0, 0, 0, 7, '0, '0, '0, '0, '0);
        step(1, 0, 1, 0, 2, '0, 2, '0, 36'h9, '0);
        step(0, 1, 0, 0, '0, 2, '0, '0, '0, '0);
        step(1, 0, 1, 1, 20, '0, 20, 25, 36'h777, 36'h888);
        step(1, 1, 0, 0, 20, 31, '0, '0, '0, '0);
        step(1, 1, 0, 0, 15, 0, '0, '0, '0, '0);
        idle(4);

        for (int i = 0; i < 400; i++) rand_step();
        idle(4);

        // Reads every cycle, reset lands just after the fourth accepting edge.
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, AW'(i), '0, '0, '0, '0, '0);
        ra = 4;
        async_reset(2);
        for (int i = 0; i < 2 * DEPTH; i++) step(1, 0, 0, 0, AW'(i % 8), '0, '0, '0, '0, '0);

        // Reset in the middle of the sweep restarts it from address 0.
        for (int i = 0; i < 10; i++) rand_step();
        async_reset(1);
        for (int i = 0; i < 5; i++) rand_step();
        async_reset(1);
        for (int i = 0; i < DEPTH; i++) rand_step();
        for (int i = 0; i < DEPTH; i++) step(1, 1, 0, 0, AW'(i), AW'(i), '0, '0, '0, '0);
        for (int i = 0; i < 100; i++) rand_step();
        idle(5);

        check("queues_drained", DW'(qsize(0) + qsize(1) + qsize(2) + qsize(3)), '0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pipelined_init_bram.md
PIPELINED_INIT_BRAM -- requirements
Module: pipelined_init_bram

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 36, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width in bits.
REQ-003 SHALL have parameter DEPTH, default 1<<ADDR_WIDTH, number of words; legal range 2..(1<<ADDR_WIDTH).
REQ-004 SHALL have parameter READ_LATENCY, default 1, cycles from accepted read to data; legal values 1 or 2.
REQ-005 SHALL have parameter INIT_VALUE, default 0, DATA_WIDTH-bit word written to every location after reset.
REQ-006 SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-007 SHALL have port RST  input  1  asynchronous, active-high reset.
REQ-008 SHALL have ports REA, REB  input  1 each  read request, port A / B.
REQ-009 SHALL have ports WEA, WEB  input  1 each  write request, port A / B.
REQ-010 SHALL have ports RD_ADDRA, RD_ADDRB  input  ADDR_WIDTH each  read address.
REQ-011 SHALL have ports WR_ADDRA, WR_ADDRB  input  ADDR_WIDTH each  write address.
REQ-012 SHALL have ports DIA, DIB  input  DATA_WIDTH each  write data.
REQ-013 SHALL have ports DOA, DOB  output  DATA_WIDTH each  read data.
REQ-014 SHALL have ports VALIDA, VALIDB  output  1 each  one-cycle pulse qualifying DOA / DOB.
REQ-015 SHALL have port INIT  output  1  high when memory is initialised and requests are accepted.
REQ-016 SHALL have port COLLIDE  output  1  sticky flag: a same-address dual-write occurred.

Function
REQ-017 SHALL implement a two-state FSM: CLEAR (entered on reset) and READY.
REQ-018 In CLEAR, SHALL write INIT_VALUE to address 0..DEPTH-1, one address per cycle via an internal counter starting at 0, advancing in the first clock edge after RST deasserts.
REQ-019 SHALL transition CLEAR->READY on the edge that writes address DEPTH-1; INIT SHALL go high in the same edge, i.e. exactly DEPTH cycles after reset release.
REQ-020 In CLEAR, SHALL ignore REA, REB, WEA, WEB entirely (no writes, no VALID pulses).
REQ-021 In READY, port X SHALL accept a write when WEX=1: mem[WR_ADDRX] <= DIX.
REQ-022 In READY, port X SHALL accept a read when REX=1 and WEX=0; REX with WEX both high: write executes, read is dropped, no VALID.
REQ-023 Accepted read SHALL produce DOX = mem[RD_ADDRX] and VALIDX=1 exactly READ_LATENCY cycles after the accepting edge; back-to-back reads fully pipelined, one per cycle per port.
REQ-024 DOX SHALL hold its last value when VALIDX=0.
REQ-025 Read of an address written by the other port in the same edge SHALL return the old (pre-write) data.
REQ-026 Both ports writing the same address in the same edge: port A data SHALL be stored, port B write discarded, COLLIDE set to 1 and held until reset.
REQ-027 Addresses >= DEPTH SHALL be ignored for writes; reads of them SHALL still pulse VALID with DO = INIT_VALUE.
REQ-028 FSM SHALL never leave READY except via RST.

Reset
REQ-029 RST assertion SHALL immediately force INIT=0, VALIDA=VALIDB=0, DOA=DOB=0, COLLIDE=0, FSM=CLEAR, counter=0, and flush read pipeline.
REQ-030 RST asserted mid-CLEAR or mid-READY SHALL restart clearing from address 0; no read issued before reset SHALL produce a VALID after it.
REQ-031 Memory contents SHALL not be reset directly; they are defined only via the CLEAR sweep.

Verification
REQ-032 Reset release, DEPTH=16 -> INIT low 16 cycles, high on 16th edge; all 16 reads then return INIT_VALUE with VALID after READ_LATENCY.
REQ-033 READY, WEA addr 5 data 0xABC, next cycle REB addr 5 -> DOB=0xABC, VALIDB pulse READ_LATENCY cycles later.
REQ-034 Same edge WEA addr 3 data 0x1, WEB addr 3 data 0x2 -> read addr 3 returns 0x1, COLLIDE=1 and stays high.
REQ-035 Same edge WEA addr 7 data 0x55 (old 0x0), REB addr 7 -> DOB=0x0; later read returns 0x55.
REQ-036 READ_LATENCY=2, REA every cycle addr 0..7, RST asserted after 4th read -> VALIDA drops at once, no further pulses, INIT low, sweep restarts at 0.
REQ-037 REA+WEA same cycle addr 2 data 0x9 -> no VALIDA pulse; later read of addr 2 returns 0x9.
